// File: rtl/ysyx22041405_lsu_if.sv
// Data-memory request/response bus: the LSU is the master, data memory is the slave.
interface ysyx22041405_lsu_if #(
  parameter int WIDTH = 32
);
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [3:0]       mem_wstrb;
  logic             mem_rsp_valid;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/ysyx22041405_lsu.sv
// Load/store unit: one operation at a time, single-outstanding memory bus,
// load data shifted down to bit 0 and handed to write-back.
module ysyx22041405_lsu #(
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   is_load,
  input  logic                   is_store,
  input  logic [1:0]             size,
  input  logic [WIDTH-1:0]       addr,
  input  logic [WIDTH-1:0]       wdata,
  ysyx22041405_lsu_if.master     mem,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       dm_addr,
  output logic [WIDTH-1:0]       dm_rdata,
  output logic                   misalign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_reg;
  logic             load_reg;
  logic             req_valid_reg;
  logic             we_reg;
  logic [WIDTH-1:0] mem_addr_reg;
  logic [WIDTH-1:0] mem_wdata_reg;
  logic [3:0]       mem_wstrb_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] dm_addr_reg;
  logic [WIDTH-1:0] dm_rdata_reg;
  logic             misalign_reg;

  logic [WIDTH-1:0] lane_wdata;
  logic [3:0]       lane_wstrb;
  logic             misaligned_in;

  // Store data is replicated across lanes so memory only needs the byte strobes.
  always_comb begin
    lane_wdata = '0;
    lane_wstrb = 4'b0000;
    if (is_store) begin
      case (size)
        2'b00: begin
          lane_wdata = {4{wdata[7:0]}};
          lane_wstrb = 4'b0001 << addr[1:0];
        end
        2'b01: begin
          lane_wdata = {2{wdata[15:0]}};
          lane_wstrb = 4'b0011 << addr[1:0];
        end
        default: begin
          lane_wdata = wdata;
          lane_wstrb = 4'b1111;
        end
      endcase
    end
  end

  assign misaligned_in = ((size == 2'b01) && addr[0]) ||
                         (size[1] && (addr[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      load_reg      <= 1'b0;
      req_valid_reg <= 1'b0;
      we_reg        <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_wstrb_reg <= 4'b0000;
      out_valid_reg <= 1'b0;
      dm_addr_reg   <= '0;
      dm_rdata_reg  <= '0;
      misalign_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            dm_addr_reg  <= addr;
            dm_rdata_reg <= '0;
            load_reg     <= is_load;
            if (!(is_load || is_store)) begin
              misalign_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else if (misaligned_in) begin
              misalign_reg  <= 1'b1;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else begin
              misalign_reg  <= 1'b0;
              req_valid_reg <= 1'b1;
              we_reg        <= is_store;
              mem_addr_reg  <= {addr[WIDTH-1:2], 2'b00};
              mem_wdata_reg <= lane_wdata;
              mem_wstrb_reg <= lane_wstrb;
              state_reg     <= REQ;
            end
          end
        end
        REQ: begin
          if (mem.mem_req_ready) begin
            req_valid_reg <= 1'b0;
            state_reg     <= WAIT;
          end
        end
        WAIT: begin
          if (mem.mem_rsp_valid) begin
            dm_rdata_reg  <= load_reg ? (mem.mem_rdata >> {dm_addr_reg[1:0], 3'b000}) : '0;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready          = (state_reg == IDLE);
  assign mem.mem_req_valid = req_valid_reg;
  assign mem.mem_we        = we_reg;
  assign mem.mem_addr      = mem_addr_reg;
  assign mem.mem_wdata     = mem_wdata_reg;
  assign mem.mem_wstrb     = mem_wstrb_reg;
  assign out_valid         = out_valid_reg;
  assign dm_addr           = dm_addr_reg;
  assign dm_rdata          = dm_rdata_reg;
  assign misalign          = misalign_reg;

endmodule

// File: tb/tb_ysyx22041405_lsu.sv
// Self-checking bench for ysyx22041405_lsu: directed scenarios plus randomized
// operations compared against a byte-level reference model.
module tb_ysyx22041405_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        is_load;
  logic        is_store;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dm_addr;
  logic [31:0] dm_rdata;
  logic        misalign;

  always #5 clk = ~clk;

  ysyx22041405_lsu_if #(.WIDTH(32)) mem_bus ();

  ysyx22041405_lsu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .is_load   (is_load),
    .is_store  (is_store),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .mem       (mem_bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dm_addr   (dm_addr),
    .dm_rdata  (dm_rdata),
    .misalign  (misalign)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  // Observations from the most recent run_op
  int          o_req_hs, o_req_seen, o_out_cycle, o_stable_err, o_busy_err;
  logic        o_we, o_mis, o_out_after, o_idle_after;
  logic [31:0] o_maddr, o_mwdata, o_dm_addr, o_dm_rdata;
  logic [3:0]  o_mwstrb;

  // Reference model: works byte by byte from the operation's size and offset.
  function automatic void model(input bit ld, input bit st, input logic [1:0] sz,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                                output bit mem_op, output bit mis, output logic [31:0] dmr,
                                output logic [31:0] wdat, output logic [3:0] strb);
    int n;
    int off;
    n      = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off    = int'(a % 4);
    mem_op = ld || st;
    mis    = mem_op && ((a % n) != 0);
    dmr    = 32'h0;
    wdat   = 32'h0;
    strb   = 4'h0;
    if (mem_op && !mis) begin
      if (ld) dmr = rd >> (8 * off);
      else begin
        for (int i = 0; i < 4; i++) begin
          wdat[8*i +: 8] = wd[8*(i % n) +: 8];
          if (i >= off && i < off + n) strb[i] = 1'b1;
        end
      end
    end
  endfunction

  // Drives one operation through the DUT with the given stall counts and records what it saw.
  task automatic run_op(input bit ld, input bit st, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int req_wait, input int rsp_wait, input int out_wait);
    int req_cyc, rsp_cyc, out_cyc;
    bit hs_next, hs_done, out_hs, done;
    o_req_hs = 0; o_req_seen = 0; o_out_cycle = 0; o_stable_err = 0; o_busy_err = 0;
    o_we = 0; o_mis = 0; o_maddr = 0; o_mwdata = 0; o_mwstrb = 0; o_dm_addr = 0; o_dm_rdata = 0;
    o_out_after = 1'bx; o_idle_after = 1'bx;
    req_cyc = 0; rsp_cyc = -1; out_cyc = 0; hs_next = 0; hs_done = 0; out_hs = 0; done = 0;
    in_valid = 1'b1; is_load = ld; is_store = st; size = sz; addr = a; wdata = wd;
    @(posedge clk); #1;
    in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; addr = $urandom; wdata = $urandom;
    for (int t = 1; t <= 100; t++) begin
      if (out_hs) begin
        o_out_after  = out_valid;
        o_idle_after = in_ready;
        done = 1;
        break;
      end
      if (in_ready !== 1'b0) o_busy_err++;
      if (hs_next) begin hs_next = 0; hs_done = 1; o_req_hs++; rsp_cyc = 0; end
      if (mem_bus.mem_req_valid === 1'b1) begin
        if (req_cyc == 0) begin
          o_we = mem_bus.mem_we; o_maddr = mem_bus.mem_addr;
          o_mwdata = mem_bus.mem_wdata; o_mwstrb = mem_bus.mem_wstrb;
        end else if ({mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata, mem_bus.mem_wstrb}
                     !== {o_we, o_maddr, o_mwdata, o_mwstrb}) o_stable_err++;
        req_cyc++; o_req_seen++;
        mem_bus.mem_req_ready = (req_cyc > req_wait);
        hs_next = mem_bus.mem_req_ready;
      end else mem_bus.mem_req_ready = 1'($urandom);
      if (hs_done && rsp_cyc >= 0) begin
        if (rsp_cyc == rsp_wait) begin
          mem_bus.mem_rsp_valid = 1'b1; mem_bus.mem_rdata = rd; rsp_cyc = -1;
        end else begin
          mem_bus.mem_rsp_valid = 1'b0; mem_bus.mem_rdata = $urandom; rsp_cyc++;
        end
      end else begin
        // Stray responses in REQ or DONE must be ignored.
        mem_bus.mem_rsp_valid = (mem_bus.mem_req_valid === 1'b1 || out_valid === 1'b1) ? 1'($urandom) : 1'b0;
        mem_bus.mem_rdata = $urandom;
      end
      if (out_valid === 1'b1) begin
        if (o_out_cycle == 0) begin
          o_out_cycle = t; o_dm_addr = dm_addr; o_dm_rdata = dm_rdata; o_mis = misalign;
        end else if ({dm_addr, dm_rdata, misalign} !== {o_dm_addr, o_dm_rdata, o_mis}) o_stable_err++;
        out_cyc++;
        out_ready = (out_cyc > out_wait);
        out_hs = out_ready;
      end else out_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    out_ready = 1'b0; mem_bus.mem_req_ready = 1'b0; mem_bus.mem_rsp_valid = 1'b0;
    if (!done) begin
      checks_total++;
      $display("FAIL op_timeout: op ld=%0d st=%0d addr=%h got no out handshake, required one within 100 cycles",
               ld, st, a);
    end
    $display("op ld=%0d st=%0d size=%0d addr=%h wdata=%h -> req_hs=%0d out_cycle=%0d dm_addr=%h dm_rdata=%h misalign=%0d",
             ld, st, sz, a, wd, o_req_hs, o_out_cycle, o_dm_addr, o_dm_rdata, o_mis);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; is_load = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1; in_valid = 1'b0; is_load = 1'b0;
    checks_total++;
    if ({in_ready, mem_bus.mem_req_valid, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata,
         mem_bus.mem_wstrb, out_valid, dm_addr, dm_rdata, misalign} !== {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
         1'b0, 32'h0, 32'h0, 1'b0})
      $display("FAIL reset_values: got in_ready=%b req_valid=%b out_valid=%b dm_rdata=%h, required 1/0/0/0",
               in_ready, mem_bus.mem_req_valid, out_valid, dm_rdata);
    else checks_passed++;
  endtask

  task automatic test_word_load();
    run_op(1, 0, 2'b10, 32'h80000010, 32'h0, 32'hDEADBEEF, 0, 0, 0);
    checks_total++;
    if ({o_we, o_maddr, o_mwstrb} !== {1'b0, 32'h80000010, 4'h0})
      $display("FAIL word_load_req: got we=%b addr=%h strb=%b, required 0/80000010/0000", o_we, o_maddr, o_mwstrb);
    else checks_passed++;
    checks_total++;
    if (o_dm_rdata !== 32'hDEADBEEF) $display("FAIL word_load_data: got %h, required deadbeef", o_dm_rdata);
    else checks_passed++;
    checks_total++;
    if (o_out_cycle !== 3) $display("FAIL word_load_latency: got %0d, required 3", o_out_cycle);
    else checks_passed++;
  endtask

  task automatic test_align_loads();
    run_op(1, 0, 2'b00, 32'h80000013, 32'h0, 32'h11223344, 0, 0, 0);
    checks_total++;
    if (o_dm_rdata !== 32'h00000011) $display("FAIL byte_load_align: got %h, required 00000011", o_dm_rdata);
    else checks_passed++;
    run_op(1, 0, 2'b01, 32'h80000012, 32'h0, 32'h11223344, 0, 0, 0);
    checks_total++;
    if (o_dm_rdata !== 32'h00001122) $display("FAIL half_load_align: got %h, required 00001122", o_dm_rdata);
    else checks_passed++;
  endtask

  task automatic test_byte_store();
    run_op(0, 1, 2'b00, 32'h80000001, 32'h000000AB, 32'h55555555, 0, 0, 0);
    checks_total++;
    if ({o_we, o_maddr, o_mwdata, o_mwstrb} !== {1'b1, 32'h80000000, 32'hABABABAB, 4'b0010})
      $display("FAIL byte_store_req: got we=%b addr=%h wdata=%h strb=%b, required 1/80000000/abababab/0010",
               o_we, o_maddr, o_mwdata, o_mwstrb);
    else checks_passed++;
    checks_total++;
    if (o_dm_rdata !== 32'h0) $display("FAIL byte_store_rdata: got %h, required 0", o_dm_rdata);
    else checks_passed++;
  endtask

  task automatic test_backpressure();
    run_op(1, 0, 2'b10, 32'h80000040, 32'h0, 32'hA5A5F00F, 3, 4, 2);
    checks_total++;
    if ({o_stable_err, o_busy_err} !== {32'd0, 32'd0})
      $display("FAIL backpressure_stable: got stable_err=%0d busy_err=%0d, required 0/0", o_stable_err, o_busy_err);
    else checks_passed++;
    checks_total++;
    if ({o_req_hs, o_req_seen} !== {32'd1, 32'd4})
      $display("FAIL backpressure_reqs: got hs=%0d valid_cycles=%0d, required 1/4", o_req_hs, o_req_seen);
    else checks_passed++;
    checks_total++;
    if ({o_out_cycle, o_dm_rdata} !== {32'd10, 32'hA5A5F00F})
      $display("FAIL backpressure_result: got cycle=%0d data=%h, required 10/a5a5f00f", o_out_cycle, o_dm_rdata);
    else checks_passed++;
  endtask

  task automatic test_misaligned();
    run_op(1, 0, 2'b10, 32'h80000002, 32'h0, 32'h12345678, 0, 0, 0);
    checks_total++;
    if (o_req_seen !== 0) $display("FAIL misalign_no_req: got %0d request cycles, required 0", o_req_seen);
    else checks_passed++;
    checks_total++;
    if ({o_out_cycle, o_mis, o_dm_rdata, o_dm_addr} !== {32'd1, 1'b1, 32'h0, 32'h80000002})
      $display("FAIL misalign_result: got cycle=%0d mis=%b data=%h addr=%h, required 1/1/0/80000002",
               o_out_cycle, o_mis, o_dm_rdata, o_dm_addr);
    else checks_passed++;
  endtask

  task automatic test_reset_in_wait();
    int stray_out;
    in_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; size = 2'b10; addr = 32'h80000020;
    @(posedge clk); #1;
    in_valid = 1'b0; is_load = 1'b0; mem_bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_bus.mem_req_ready = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks_total++;
    if ({in_ready, mem_bus.mem_req_valid, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata,
         mem_bus.mem_wstrb, out_valid, dm_addr, dm_rdata, misalign} !== {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
         1'b0, 32'h0, 32'h0, 1'b0})
      $display("FAIL reset_in_wait: got in_ready=%b mem_addr=%h out_valid=%b dm_addr=%h, required 1/0/0/0",
               in_ready, mem_bus.mem_addr, out_valid, dm_addr);
    else checks_passed++;
    mem_bus.mem_rsp_valid = 1'b1; mem_bus.mem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    mem_bus.mem_rsp_valid = 1'b0;
    stray_out = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid !== 1'b0 || dm_rdata !== 32'h0) stray_out++;
      @(posedge clk); #1;
    end
    checks_total++;
    if (stray_out !== 0) $display("FAIL stray_rsp_ignored: got %0d cycles with output, required 0", stray_out);
    else checks_passed++;
    run_op(1, 0, 2'b01, 32'h80000022, 32'h0, 32'hBEEF1234, 1, 1, 0);
    checks_total++;
    if ({o_dm_rdata, o_out_cycle} !== {32'h0000BEEF, 32'd5})
      $display("FAIL after_reset_op: got data=%h cycle=%0d, required 0000beef/5", o_dm_rdata, o_out_cycle);
    else checks_passed++;
  endtask

  task automatic test_random();
    bit ld, st, mem_op, mis;
    logic [1:0] sz;
    logic [31:0] a, wd, rd, e_dmr, e_wdat;
    logic [3:0] e_strb;
    int rq, rs, ow, e_cycle;
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 3))
        0:       begin ld = 0; st = 0; end
        1, 3:    begin ld = 1; st = 0; end
        default: begin ld = 0; st = 1; end
      endcase
      sz = 2'($urandom); a = 32'h80000000 | ($urandom & 32'hFF);
      wd = $urandom; rd = $urandom;
      rq = $urandom_range(0, 3); rs = $urandom_range(0, 3); ow = $urandom_range(0, 2);
      model(ld, st, sz, a, wd, rd, mem_op, mis, e_dmr, e_wdat, e_strb);
      e_cycle = (mem_op && !mis) ? 3 + rq + rs : 1;
      run_op(ld, st, sz, a, wd, rd, rq, rs, ow);
      checks_total++;
      if ({o_dm_rdata, o_mis, o_dm_addr} !== {e_dmr, mis, a})
        $display("FAIL rand_result[%0d]: got data=%h mis=%b addr=%h, required %h/%b/%h",
                 k, o_dm_rdata, o_mis, o_dm_addr, e_dmr, mis, a);
      else checks_passed++;
      checks_total++;
      if ({o_out_cycle, o_req_hs} !== {e_cycle, ((mem_op && !mis) ? 32'd1 : 32'd0)})
        $display("FAIL rand_timing[%0d]: got cycle=%0d reqs=%0d, required %0d/%0d",
                 k, o_out_cycle, o_req_hs, e_cycle, (mem_op && !mis) ? 1 : 0);
      else checks_passed++;
      if (mem_op && !mis) begin
        checks_total++;
        if ({o_we, o_maddr, o_mwdata, o_mwstrb} !== {st, a - (a % 4), e_wdat, e_strb})
          $display("FAIL rand_bus[%0d]: got we=%b addr=%h wdata=%h strb=%b, required %b/%h/%h/%b",
                   k, o_we, o_maddr, o_mwdata, o_mwstrb, st, a - (a % 4), e_wdat, e_strb);
        else checks_passed++;
      end
      checks_total++;
      if ({o_stable_err, o_busy_err, o_out_after, o_idle_after} !== {32'd0, 32'd0, 1'b0, 1'b1})
        $display("FAIL rand_handshake[%0d]: got stable_err=%0d busy_err=%0d out_after=%b idle_after=%b, required 0/0/0/1",
                 k, o_stable_err, o_busy_err, o_out_after, o_idle_after);
      else checks_passed++;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; size = 2'b00;
    addr = 32'h0; wdata = 32'h0; out_ready = 1'b0;
    mem_bus.mem_req_ready = 1'b0; mem_bus.mem_rsp_valid = 1'b0; mem_bus.mem_rdata = 32'h0;
    test_reset();
    test_word_load();
    test_align_loads();
    test_byte_store();
    test_backpressure();
    test_misaligned();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
